// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a one-word holding register.
//
// Input serial_rx is synchronised, then decoded by a start/data/parity/stop
// FSM that samples each bit at its midpoint. A completed frame is loaded into
// the holding register and presented on a valid/ready handshake. Errored frames
// are still delivered, with their flags.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   serial_rx    asynchronous serial line, idles high
//   rx_data      received word, valid while rx_valid=1
//   rx_valid     holding register full
//   rx_ready     consumer accepts the word when rx_valid & rx_ready
//   parity_err   parity mismatch for the held word
//   framing_err  a stop bit was sampled low for the held word
//   overrun_err  sticky: a frame completed while the register was full
//   busy         receiver is not idle
module uart_rx_param #(
    parameter int CLK_FREQ_HZ = 33330000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(HALF);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] PARITY     = 3'd3;
    localparam logic [2:0] STOP       = 3'd4;
    localparam logic [2:0] BREAK_WAIT = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_idx;
    logic                   perr;
    logic                   ferr;
    logic [DATA_BITS-1:0]   shift;
    logic                   mid_bit;
    logic                   frame_done;
    logic                   ferr_now;
    logic                   accept;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign mid_bit    = (cnt == CNT_MAX);
    assign frame_done = (state == STOP) && mid_bit && (stop_idx == LAST_STOP);
    // The final stop sample is folded in directly; ferr itself updates on the same edge.
    assign ferr_now   = ferr | ~rx_s;
    assign accept     = rx_valid & rx_ready;
    assign busy       = (state != IDLE);

    // Synchroniser and receive FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_rx};
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        // Counting from mid start bit makes every later sample land mid-bit.
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX)
                            state <= (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        cnt   <= '0;
                        perr  <= ((^shift) ^ rx_s) != (PARITY_MODE == 1);
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        cnt <= '0;
                        if (!rx_s) ferr <= 1'b1;
                        if (stop_idx == LAST_STOP)
                            // A line still low here is a break; wait it out before re-arming.
                            state <= rx_s ? IDLE : BREAK_WAIT;
                        else
                            stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data shift register: LSB arrives first, so shift in from the top
    always_ff @(posedge clk) begin
        if ((state == DATA) && mid_bit)
            shift <= {rx_s, shift[DATA_BITS-1:1]};
    end

    // Holding register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data     <= shift;
            parity_err  <= perr;
            framing_err <= ferr_now;
            rx_valid    <= 1'b1;
            overrun_err <= 1'b0;
        end else if (frame_done) begin
            overrun_err <= 1'b1;
        end else if (accept) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule
